// File: rtl/period_meter.sv
// Measures the rising-to-rising period of an asynchronous slow signal in clk_in cycles.
// Optional lock detection is enabled by defining PERIOD_METER_LOCK_EN.
module period_meter #(
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 60000,
  parameter int EXPECTED   = 50000,
  parameter int TOL        = 16,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             period_ack,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             overrun,
  output logic             timeout,
  output logic             locked
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_TIMEOUT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc_d;
  logic [CNT_W-1:0] period_q;
  logic             valid_q;
  logic             overrun_q;
  logic             timeout_q;
  logic             sync1_q;
  logic             sync2_q;
  logic             sync3_q;
  logic             edge_q;
  logic             ack_take;

  // Synchronizer, delay flop and registered rising-edge pulse.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      edge_q  <= sync2_q & ~sync3_q;
    end
  end

  // Saturating increment and acknowledge qualification.
  always_comb begin
    cnt_inc_d = cnt_q;
    if (cnt_q != CNT_MAX) begin
      cnt_inc_d = cnt_q + CNT_ONE;
    end else begin
      cnt_inc_d = CNT_MAX;
    end
    ack_take = period_ack & valid_q;
  end

  // Measurement FSM with registered result, valid, overrun and timeout flags.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (ack_take) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (edge_q) begin
            cnt_q   <= CNT_ONE;
            state_q <= S_MEASURE;
          end
        end
        S_MEASURE: begin
          if (edge_q) begin
            period_q <= cnt_q;
            valid_q  <= 1'b1;
            cnt_q    <= CNT_ONE;
            if (valid_q && !period_ack) begin
              overrun_q <= 1'b1;
            end
          end else if (cnt_q == TIMEOUT_C) begin
            // Partial count is discarded; the next edge restarts cleanly.
            cnt_q     <= '0;
            timeout_q <= 1'b1;
            state_q   <= S_TIMEOUT;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        S_TIMEOUT: begin
          if (edge_q) begin
            cnt_q     <= CNT_ONE;
            timeout_q <= 1'b0;
            state_q   <= S_MEASURE;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          cnt_q     <= '0;
          timeout_q <= 1'b0;
        end
      endcase
    end
  end

  assign period_out   = period_q;
  assign period_valid = valid_q;
  assign overrun      = overrun_q;
  assign timeout      = timeout_q;

`ifdef PERIOD_METER_LOCK_EN
  localparam int              LC_W   = $clog2(LOCK_COUNT + 1);
  localparam logic [LC_W-1:0] LC_MAX = LC_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] EXP_C = CNT_W'(EXPECTED);
  localparam logic [CNT_W-1:0] TOL_C = CNT_W'(TOL);

  logic [LC_W-1:0] lock_cnt_q;
  logic [LC_W-1:0] lock_cnt_d;
  logic            in_tol;
  logic            locked_q;

  // Consecutive in-tolerance capture counter, cleared on a miss or timeout.
  always_comb begin
    in_tol     = 1'b0;
    lock_cnt_d = lock_cnt_q;
    if (cnt_q >= EXP_C) begin
      in_tol = ((cnt_q - EXP_C) <= TOL_C);
    end else begin
      in_tol = ((EXP_C - cnt_q) <= TOL_C);
    end
    if (state_q == S_MEASURE) begin
      if (edge_q) begin
        if (!in_tol) begin
          lock_cnt_d = '0;
        end else if (lock_cnt_q != LC_MAX) begin
          lock_cnt_d = lock_cnt_q + LC_W'(1);
        end else begin
          lock_cnt_d = LC_MAX;
        end
      end else if (cnt_q == TIMEOUT_C) begin
        lock_cnt_d = '0;
      end else begin
        lock_cnt_d = lock_cnt_q;
      end
    end else begin
      lock_cnt_d = lock_cnt_q;
    end
  end

  // Lock state registers.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= (lock_cnt_d == LC_MAX);
    end
  end

  assign locked = locked_q;
`else
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_period_meter.sv
// Directed table-driven bench for period_meter (CNT_W=8, TIMEOUT=200, EXPECTED=100, TOL=2).
module tb_period_meter;

  logic       clk_in     = 1'b0;
  logic       rst_n      = 1'b0;
  logic       sig_in     = 1'b0;
  logic       period_ack = 1'b0;
  logic [7:0] period_out;
  logic       period_valid;
  logic       overrun;
  logic       timeout;
  logic       locked;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef PERIOD_METER_LOCK_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif

  // mode: 0 no ack, 1 ack after the capture, 2 ack coincident with capture then ack again
  typedef struct {
    int gap;
    int mode;
    int exp_period;
    bit exp_valid;
    bit exp_overrun;
    bit exp_locked;
    bit chk_lat;
  } vec_t;

  vec_t tbl[13];

  period_meter #(
    .CNT_W(8), .TIMEOUT(200), .EXPECTED(100), .TOL(2), .LOCK_COUNT(4)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .sig_in(sig_in), .period_ack(period_ack),
    .period_out(period_out), .period_valid(period_valid), .overrun(overrun),
    .timeout(timeout), .locked(locked)
  );

  always #5 clk_in = ~clk_in;

  function automatic vec_t mk(input int gap, input int mode, input int p, input bit v,
                              input bit o, input bit l, input bit lat);
    vec_t r;
    r.gap = gap; r.mode = mode; r.exp_period = p; r.exp_valid = v;
    r.exp_overrun = o; r.exp_locked = l; r.chk_lat = lat;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " period_out"}, int'(period_out), 0);
    check({tag, " period_valid"}, int'(period_valid), 0);
    check({tag, " overrun"}, int'(overrun), 0);
    check({tag, " timeout"}, int'(timeout), 0);
    check({tag, " locked"}, int'(locked), 0);
  endtask

  // Called on a negedge: raises sig_in, checks the capture, then completes gap cycles.
  task automatic apply(input vec_t v, input string tag);
    int used;
    sig_in = 1'b1;
    repeat (3) @(negedge clk_in);
    if (v.chk_lat) check({tag, " valid before latency"}, int'(period_valid), 0);
    if (v.mode == 2) period_ack = 1'b1;
    @(negedge clk_in);
    period_ack = 1'b0;
    check({tag, " period_out"}, int'(period_out), v.exp_period);
    check({tag, " period_valid"}, int'(period_valid), int'(v.exp_valid));
    check({tag, " overrun"}, int'(overrun), int'(v.exp_overrun));
    check({tag, " timeout"}, int'(timeout), 0);
    check({tag, " locked"}, int'(locked), int'(v.exp_locked & LOCK_ON));
    used = 4;
    if (v.mode != 0) begin
      period_ack = 1'b1;
      @(negedge clk_in);
      period_ack = 1'b0;
      used++;
      check({tag, " valid after ack"}, int'(period_valid), 0);
      check({tag, " overrun after ack"}, int'(overrun), 0);
    end
    repeat (v.gap / 2 - used) @(negedge clk_in);
    sig_in = 1'b0;
    repeat (v.gap - v.gap / 2) @(negedge clk_in);
  endtask

  initial begin
    tbl[0]  = mk(100, 0,   0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(100, 1, 100, 1'b1, 1'b0, 1'b0, 1'b1);
    tbl[2]  = mk(100, 1, 100, 1'b1, 1'b0, 1'b0, 1'b1);
    tbl[3]  = mk( 98, 0, 100, 1'b1, 1'b0, 1'b0, 1'b1);
    tbl[4]  = mk(100, 1,  98, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[5]  = mk(100, 0, 100, 1'b1, 1'b0, 1'b1, 1'b1);
    tbl[6]  = mk(105, 2, 100, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[7]  = mk(101, 1, 105, 1'b1, 1'b0, 1'b0, 1'b1);
    tbl[8]  = mk( 99, 1, 101, 1'b1, 1'b0, 1'b0, 1'b1);
    tbl[9]  = mk(100, 1,  99, 1'b1, 1'b0, 1'b0, 1'b1);
    tbl[10] = mk(102, 1, 100, 1'b1, 1'b0, 1'b0, 1'b1);
    tbl[11] = mk(105, 1, 102, 1'b1, 1'b0, 1'b1, 1'b1);
    tbl[12] = mk(100, 1, 105, 1'b1, 1'b0, 1'b0, 1'b1);

    repeat (3) @(negedge clk_in);
    check_all_zero("in reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk_in);
    check_all_zero("after reset");

    for (int i = 0; i < 13; i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // sig_in stays low: timeout after 200 counted cycles, no capture.
    check("pre-timeout timeout", int'(timeout), 0);
    repeat (95) @(negedge clk_in);
    check("near-timeout timeout", int'(timeout), 0);
    repeat (15) @(negedge clk_in);
    check("timeout asserted", int'(timeout), 1);
    check("timeout valid", int'(period_valid), 0);
    check("timeout period_out", int'(period_out), 105);
    check("timeout locked", int'(locked), 0);
    apply(mk(100, 0, 105, 1'b0, 1'b0, 1'b0, 1'b0), "timeout exit");
    apply(mk( 60, 1, 100, 1'b1, 1'b0, 1'b0, 1'b1), "post-timeout");

    // Reset mid-measurement with a valid capture pending.
    sig_in = 1'b1;
    repeat (4) @(negedge clk_in);
    check("pre-reset valid", int'(period_valid), 1);
    check("pre-reset period_out", int'(period_out), 60);
    repeat (10) @(negedge clk_in);
    #1 rst_n = 1'b0;
    #1 check_all_zero("async reset");
    sig_in = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_in);
    check_all_zero("reset release");
    period_ack = 1'b1;
    @(negedge clk_in);
    period_ack = 1'b0;
    check("stray ack valid", int'(period_valid), 0);
    check("stray ack overrun", int'(overrun), 0);
    apply(mk(50, 0,  0, 1'b0, 1'b0, 1'b0, 1'b0), "post-reset first");
    apply(mk(50, 1, 50, 1'b1, 1'b0, 1'b0, 1'b1), "post-reset second");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
